// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Purpose  : Shared types and constants for the multiply/divide unit:
//            instruction opcodes, controller states, default latencies and
//            the divide-by-zero quotient pattern.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

  // Multiply/divide opcodes presented by the EXE stage
  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } mdu_op_t;

  // Controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } mdu_state_t;

  localparam int          c_MUL_LAT_DEF   = 2;
  localparam int          c_DIV_ITERS_DEF = 32;
  localparam logic [31:0] c_DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  // True for the opcodes that need the multi-cycle datapath
  function automatic logic is_muldiv(input logic [3:0] o);
    return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Restoring unsigned divider, one quotient bit per cycle.
//            quotient/remainder show the result of the iteration being
//            performed this cycle, so when 'last' is high they hold the final
//            values and can be captured on the same clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
  import cpu_defs::*;
#(
  parameter int DIV_ITERS = c_DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  localparam int c_CNT_W = $clog2(DIV_ITERS + 1);

  logic [31:0]        r_rem;
  logic [31:0]        r_quo;
  logic [31:0]        r_dvs;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_active;

  logic [32:0]        w_shift;
  logic [32:0]        w_diff;
  logic               w_fit;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    w_shift = {r_rem, r_quo[31]};
    w_diff  = w_shift - {1'b0, r_dvs};
    w_fit   = ~w_diff[32];
  end

  assign quotient  = {r_quo[30:0], w_fit};
  assign remainder = w_fit ? w_diff[31:0] : w_shift[31:0];
  assign last      = r_active && (r_cnt == '0);

  // Iteration registers: load on start, shift one bit per active cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (abort) begin
      r_active <= 1'b0;
    end else if (start) begin
      r_rem    <= '0;
      r_quo    <= dividend;
      r_dvs    <= divisor;
      r_cnt    <= c_CNT_W'(DIV_ITERS - 1);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem <= remainder;
      r_quo <= quotient;
      r_cnt <= r_cnt - c_CNT_W'(1);
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : EXE-stage multiply/divide controller. Sequences the multiplier
//            and the iterative divider, owns HI/LO, and produces ready/result
//            for the EXE ready_go. HI/LO are only written on an ack that is
//            neither flushed nor write-disabled; flush aborts any operation.
// Options  : MDU_DIV_EARLY_EN - when defined, divides whose quotient is
//            trivially zero (|divisor| > |dividend| or dividend == 0) finish
//            after a single busy cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import cpu_defs::*;
#(
  parameter int MUL_LAT   = c_MUL_LAT_DEF,
  parameter int DIV_ITERS = c_DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ack,
  input  logic        wr_disable,
  input  logic        flush,
  output logic        ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int c_CNT_MAX = (DIV_ITERS > MUL_LAT) ? DIV_ITERS : MUL_LAT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  mdu_state_t         r_state;
  mdu_state_t         w_state_next;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_hi_tmp;
  logic [31:0]        r_lo_tmp;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic               r_signed;
  logic               r_s1;
  logic               r_s2;
  logic               r_early;
  logic               r_div_zero;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_start_mul;
  logic               w_start_div;
  logic               w_div_signed;
  logic [31:0]        w_mag1;
  logic [31:0]        w_mag2;
  logic               w_early;
  logic [63:0]        w_mul_a;
  logic [63:0]        w_mul_b;
  logic [63:0]        w_prod;
  logic [31:0]        w_div_q;
  logic [31:0]        w_div_r;
  logic               w_div_last;
  logic               w_div_done;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q_fix;
  logic [31:0]        w_r_fix;
  logic               w_commit;

  assign w_is_mul     = (op == MULT) || (op == MULTU);
  assign w_is_div     = (op == DIV)  || (op == DIVU);
  assign w_start_mul  = (r_state == IDLE) && op_valid && w_is_mul && !flush;
  assign w_start_div  = (r_state == IDLE) && op_valid && w_is_div && !flush;
  assign w_div_signed = (op == DIV);

  // Divider works on magnitudes; signs are re-applied at completion
  assign w_mag1 = (w_div_signed && src1[31]) ? (32'd0 - src1) : src1;
  assign w_mag2 = (w_div_signed && src2[31]) ? (32'd0 - src2) : src2;

`ifdef MDU_DIV_EARLY_EN
  assign w_early = (w_mag2 > w_mag1) || (w_mag1 == 32'd0);
`else
  assign w_early = 1'b0;
`endif

  // Multiplier: operands extended to 64 bits so the low 64 product bits are
  // correct for both signed and unsigned forms
  assign w_mul_a = r_signed ? {{32{r_op_a[31]}}, r_op_a} : {32'd0, r_op_a};
  assign w_mul_b = r_signed ? {{32{r_op_b[31]}}, r_op_b} : {32'd0, r_op_b};
  assign w_prod  = w_mul_a * w_mul_b;

  div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start_div && !w_early),
    .abort     (flush),
    .dividend  (w_mag1),
    .divisor   (w_mag2),
    .quotient  (w_div_q),
    .remainder (w_div_r),
    .last      (w_div_last)
  );

  assign w_div_done = r_early ? (r_count == '0) : w_div_last;

  // Final divide result: early-out and divide-by-zero patterns, then sign fix
  assign w_q_mag = r_early    ? 32'd0 :
                   r_div_zero ? c_DIV_BY_ZERO_Q : w_div_q;
  assign w_r_mag = r_early ? r_op_a : w_div_r;
  assign w_q_fix = (r_signed && (r_s1 ^ r_s2)) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_fix = (r_signed && r_s1) ? (32'd0 - w_r_mag) : w_r_mag;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_mul) begin
            w_state_next = MUL_BUSY;
          end else if (w_start_div) begin
            w_state_next = DIV_BUSY;
          end
        end
        MUL_BUSY: begin
          if (r_count == '0) begin
            w_state_next = DONE;
          end
        end
        DIV_BUSY: begin
          if (w_div_done) begin
            w_state_next = DONE;
          end
        end
        DONE: begin
          if (ack) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Operand latch, cycle counter and 64-bit result temporaries
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_hi_tmp   <= '0;
      r_lo_tmp   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_signed   <= 1'b0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_early    <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_mul) begin
            r_op_a   <= src1;
            r_op_b   <= src2;
            r_signed <= (op == MULT);
            r_count  <= c_CNT_W'(MUL_LAT - 1);
          end else if (w_start_div) begin
            r_op_a     <= w_mag1;
            r_signed   <= w_div_signed;
            r_s1       <= src1[31];
            r_s2       <= src2[31];
            r_early    <= w_early;
            r_div_zero <= (w_mag2 == 32'd0);
            r_count    <= w_early ? '0 : c_CNT_W'(DIV_ITERS - 1);
          end
        end
        MUL_BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - c_CNT_W'(1);
          end else begin
            r_hi_tmp <= w_prod[63:32];
            r_lo_tmp <= w_prod[31:0];
          end
        end
        DIV_BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - c_CNT_W'(1);
          end
          if (w_div_done) begin
            r_hi_tmp <= w_r_fix;
            r_lo_tmp <= w_q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_commit = ack && !wr_disable && !flush;

  // Architectural HI/LO, written only on a committed ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (r_state == DONE) begin
        r_hi <= r_hi_tmp;
        r_lo <= r_lo_tmp;
      end else if (op_valid && (op == MTHI)) begin
        r_hi <= src1;
      end else if (op_valid && (op == MTLO)) begin
        r_lo <= src1;
      end
    end
  end

  // Handshake and read-port outputs
  always_comb begin
    ready  = !op_valid || !is_muldiv(op) || (r_state == DONE);
    busy   = (r_state != IDLE);
    result = 32'd0;
    if (op == MFHI) begin
      result = r_hi;
    end else if (op == MFLO) begin
      result = r_lo;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Directed self-checking bench for mdu_ctrl (MUL_LAT=2,
//            DIV_ITERS=32). Expected values are hand-computed constants.
//            Honours MDU_DIV_EARLY_EN for the early-out latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
  import cpu_defs::*;

`ifdef MDU_DIV_EARLY_EN
  localparam int c_EARLY_LAT = 2;
`else
  localparam int c_EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ack;
  logic        wr_disable;
  logic        flush;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mdu_ctrl #(
    .MUL_LAT   (2),
    .DIV_ITERS (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .ack        (ack),
    .wr_disable (wr_disable),
    .flush      (flush),
    .ready      (ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---- stimulus helpers (no checking inside) ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    ack      = 1'b0;
    #1;
  endtask

  task automatic wait_ready(output int n, output bit timed_out);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    timed_out = !ready;
  endtask

  task automatic finish_op(input logic wd);
    ack        = 1'b1;
    wr_disable = wd;
    tick();
    ack        = 1'b0;
    wr_disable = 1'b0;
    op_valid   = 1'b0;
    op         = NOP;
    #1;
  endtask

  task automatic mf_read(input logic [3:0] o, output logic [31:0] v);
    op_valid = 1'b1;
    op       = o;
    ack      = 1'b0;
    #1;
    v = result;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; op_valid = 1'b0; op = NOP; src1 = '0; src2 = '0;
    ack = 1'b0; wr_disable = 1'b0; flush = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", v); end
    mf_read(MFLO, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", v); end
    op_valid = 1'b0; op = NOP;
  endtask

  task automatic test_mult();
    int n; bit to; logic [31:0] v;
    issue(MULT, 32'hFFFF_FFFD, 32'd5);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mult_ready_low: got %b expected 0", ready); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", busy); end
    wait_ready(n, to);
    checks++; if (to || n != 2) begin errors++; $display("FAIL mult_latency: got %0d expected 3", n + 1); end
    finish_op(1'b0);
    mf_read(MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", v); end
    mf_read(MFLO, v);
    checks++; if (v !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", v); end
  endtask

  task automatic test_div();
    int n; bit to; logic [31:0] v;
    issue(DIVU, 32'd100, 32'd7);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", v); end

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL div_neg_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", v); end

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL div_ovf_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", v); end
  endtask

  task automatic test_div_zero();
    int n; bit to; logic [31:0] v;
    issue(DIV, 32'hFFFF_FFFA, 32'd0);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL sdivz_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL sdivz_lo: got %h expected 00000001", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'hFFFF_FFFA) begin errors++; $display("FAIL sdivz_hi: got %h expected fffffffa", v); end

    issue(DIVU, 32'd5, 32'd0);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL divz_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL divz_hi: got %h expected 00000005", v); end
  endtask

  task automatic test_flush();
    int n; bit to; logic [31:0] v;
    issue(DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd5) begin errors++; $display("FAIL flush_hi_kept: got %h expected 00000005", v); end
    mf_read(MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_lo_kept: got %h expected ffffffff", v); end
    issue(DIVU, 32'd50, 32'd6);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL flush_new_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL flush_new_lo: got %h expected 00000008", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL flush_new_hi: got %h expected 00000002", v); end
  endtask

  task automatic test_wr_disable();
    int n; bit to; logic [31:0] v;
    issue(MULT, 32'd3, 32'd4);
    wait_ready(n, to);
    checks++; if (to || n != 3) begin errors++; $display("FAIL wrdis_latency: got %0d expected 3", n); end
    finish_op(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrdis_idle: got busy %b expected 0", busy); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL wrdis_hi: got %h expected 00000002", v); end
    mf_read(MFLO, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL wrdis_lo: got %h expected 00000008", v); end

    issue(MTHI, 32'h0000_1234, 32'd0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mthi_ready: got %b expected 1", ready); end
    finish_op(1'b0);
    mf_read(MFHI, v);
    checks++; if (v !== 32'h0000_1234) begin errors++; $display("FAIL mthi_read: got %h expected 00001234", v); end

    issue(MTLO, 32'h0000_AAAA, 32'd0);
    finish_op(1'b1);
    issue(MTLO, 32'h0000_5555, 32'd0);
    flush = 1'b1;
    finish_op(1'b0);
    flush = 1'b0;
    mf_read(MFLO, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL mtlo_blocked: got %h expected 00000008", v); end
  endtask

  task automatic test_early();
    int n; bit to; logic [31:0] v;
    issue(DIVU, 32'd3, 32'd9);
    wait_ready(n, to);
    checks++; if (to || n != c_EARLY_LAT) begin errors++; $display("FAIL early_latency: got %0d expected %0d", n, c_EARLY_LAT); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL early_lo: got %h expected 00000000", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL early_hi: got %h expected 00000003", v); end

    issue(DIV, 32'd0, 32'hFFFF_FFFB);
    wait_ready(n, to);
    checks++; if (to || n != c_EARLY_LAT) begin errors++; $display("FAIL early_zero_latency: got %0d expected %0d", n, c_EARLY_LAT); end
    finish_op(1'b0);
    mf_read(MFHI, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL early_zero_hi: got %h expected 00000000", v); end
  endtask

  task automatic test_back_to_back();
    int n; bit to; logic [31:0] v;
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_ready(n, to);
    checks++; if (to || n != 3) begin errors++; $display("FAIL b2b_mul_latency: got %0d expected 3", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_multu_lo: got %h expected fffffffe", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL b2b_multu_hi: got %h expected 00000001", v); end
    issue(DIVU, 32'd42, 32'd5);
    wait_ready(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL b2b_div_latency: got %0d expected 33", n); end
    finish_op(1'b0);
    mf_read(MFLO, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL b2b_div_lo: got %h expected 00000008", v); end
    mf_read(MFHI, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL b2b_div_hi: got %h expected 00000002", v); end
    op_valid = 1'b0; op = NOP;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_wr_disable();
    test_early();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
